// File: rtl/luces_intermitentes_multicanal.sv
// N-channel LED flasher: shared base-tick prescaler, blink-pulse timer and
// per-channel mode decode into a registered LED bank.
module luces_intermitentes_multicanal #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PERIOD_CYC = 50_000_000,
  parameter int unsigned PULSE_CYC  = 10_000_000,
  parameter int unsigned ALTERNAR   = 1
) (
  input  logic              Reloj,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [2*N_CH-1:0] Modo,
  output logic              Tick,
  output logic [N_CH-1:0]   LED
);

  localparam int unsigned CW = $clog2(PERIOD_CYC);
  localparam int unsigned PW = $clog2(PULSE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD_CYC - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYC);

  typedef enum logic [1:0] {
    MODO_APAGADO = 2'b00,
    MODO_FIJO    = 2'b01,
    MODO_CONMUTA = 2'b10,
    MODO_PULSO   = 2'b11
  } modo_e;

  logic [CW-1:0]   cnt;
  logic [PW-1:0]   pcnt;
  logic            base;
  logic            pulse;
  logic            fin_periodo;
  logic [N_CH-1:0] led_next;

  assign fin_periodo = Enable && (cnt == CNT_LAST);
  assign pulse       = (pcnt != '0);

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      cnt  <= '0;
      base <= 1'b0;
      pcnt <= '0;
      Tick <= 1'b0;
      LED  <= '0;
    end else begin
      Tick <= fin_periodo;
      if (fin_periodo) begin
        cnt  <= '0;
        base <= ~base;
      end else if (Enable) begin
        cnt <= cnt + 1'b1;
      end
      // A tick reloads the pulse even while it is still running, so no gap.
      if (fin_periodo) begin
        pcnt <= PULSE_LOAD;
      end else if (Enable && pulse) begin
        pcnt <= pcnt - 1'b1;
      end
      LED <= led_next;
    end
  end

  always_comb begin
    led_next = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      case (modo_e'(Modo[2*i +: 2]))
        MODO_APAGADO: led_next[i] = 1'b0;
        MODO_FIJO:    led_next[i] = 1'b1;
        MODO_CONMUTA: led_next[i] = ((ALTERNAR != 0) && (i % 2 == 1)) ? ~base : base;
        MODO_PULSO:   led_next[i] = pulse;
        default:      led_next[i] = 1'b0;
      endcase
    end
  end

endmodule
